// File: rtl/ones_complement_serial_adder_pkg.sv
// rtl/ones_complement_serial_adder_pkg.sv - shared FSM state encoding for the serial one's-complement adder
package ones_complement_serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_WRAP = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/ones_complement_serial_adder_full_adder_bit.sv
// rtl/ones_complement_serial_adder_full_adder_bit.sv - combinational 1-bit full adder cell
module full_adder_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/ones_complement_serial_adder.sv
// rtl/ones_complement_serial_adder.sv - bit-serial one's-complement adder with end-around carry pass
module ones_complement_serial_adder
   import ones_complement_serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] sum,
   output logic             eac
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-2:0] r_work;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_eac;
   logic [CW-1:0]    r_cnt;

   logic             w_s;
   logic             w_co;
   logic             w_last;
   logic [WIDTH-1:0] w_word;

   full_adder_bit u_fa (
      .i_a (r_a_sr[0]),
      .i_b (r_b_sr[0]),
      .i_c (r_carry),
      .o_s (w_s),
      .o_c (w_co)
   );

   assign w_last = (r_cnt == CW'(WIDTH - 1));
   // Work register plus the current bit form the LSB-aligned word on the last step
   assign w_word = {w_s, r_work};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (start) w_next = S_ADD;
         S_ADD:  if (w_last) w_next = w_co ? S_WRAP : S_DONE;
         S_WRAP: if (w_last) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_work  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_eac   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_carry <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            S_ADD, S_WRAP: begin
               r_a_sr  <= r_a_sr >> 1;
               r_b_sr  <= r_b_sr >> 1;
               r_work  <= w_word[WIDTH-1:1];
               r_carry <= w_co;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  if (r_state == S_ADD && w_co) begin
                     // Second pass re-adds the carry-out at bit 0
                     r_a_sr  <= w_word;
                     r_b_sr  <= '0;
                     r_carry <= 1'b1;
                     r_eac   <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_sum <= w_word;
                     if (r_state == S_ADD) r_eac <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ready = (r_state == S_IDLE);
   assign busy  = (r_state == S_ADD) || (r_state == S_WRAP);
   assign valid = (r_state == S_DONE);
   assign sum   = r_sum;
   assign eac   = r_eac;

endmodule

// File: tb/tb_ones_complement_serial_adder.sv
// tb/tb_ones_complement_serial_adder.sv - scoreboard bench for the serial one's-complement adder
module tb_ones_complement_serial_adder;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         ready;
   logic         busy;
   logic         valid;
   logic [W-1:0] sum;
   logic         eac;

   ones_complement_serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .valid (valid),
      .sum   (sum),
      .eac   (eac)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] s;
      logic         e;
      int           lat;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input longint act, input longint expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // One's-complement sum from plain integer arithmetic
   function automatic exp_t model(input int x, input int y);
      exp_t r;
      int   raw;
      raw = x + y;
      if (raw >= (1 << W)) begin
         r.s   = W'(raw - (1 << W) + 1);
         r.e   = 1'b1;
         r.lat = 2 * W + 1;
      end else begin
         r.s   = W'(raw);
         r.e   = 1'b0;
         r.lat = W + 1;
      end
      r.acc = 0;
      return r;
   endfunction

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      int   t;
      @(negedge clk);
      t = 0;
      while (!ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!ready) chk("ready_wait_timeout", 0, 1);
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      e     = model(int'(x), int'(y));
      e.acc = cyc;
      q.push_back(e);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (q.size() == 0) break;
         @(posedge clk);
      end
      chk("drain_timeout", q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sum", sum, e.s);
            chk("eac", eac, e.e);
            chk("latency", cyc - e.acc + 1, e.lat);
            chk("ready_in_done", ready, 0);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_eac", eac, 0);
      rst_n = 1'b1;

      issue(8'h05, 8'h03); drain();
      issue(8'hFE, 8'h02); drain();
      issue(8'hFF, 8'hFF); drain();
      issue(8'h05, 8'hFA); drain();

      // Start pulses while busy must be dropped
      issue(8'h05, 8'h03);
      repeat (3) begin
         @(negedge clk);
         chk("busy_ready", ready, 0);
         chk("busy_busy", busy, 1);
         a     = 8'h11;
         b     = 8'h22;
         start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (3) @(negedge clk);

      issue(8'h10, 8'h20);
      issue(8'h30, 8'hE0);
      issue(8'h7F, 8'h80);
      drain();

      // Reset in the middle of the wrap pass
      issue(8'hFE, 8'h02);
      repeat (12) @(negedge clk);
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_eac", eac, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      issue(8'h01, 8'h01); drain();

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] x;
         logic [W-1:0] y;
         x = W'($urandom);
         y = W'($urandom);
         if ($urandom_range(0, 7) == 0) y = ~x;
         if ($urandom_range(0, 7) == 0) x = 8'hFF;
         issue(x, y);
         if ($urandom_range(0, 3) == 0) drain();
      end
      drain();
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ones_complement_serial_adder.md
Name: ones_complement_serial_adder

Overview:
Bit-serial one's-complement adder with end-around carry. It is the addition counterpart of the team's combinational one's-complement subtractor, and re-forms a minuend from a difference plus subtrahend. Operands enter through a start/ready handshake and are added LSB-first, one bit per clock. If the word addition carries out, a second serial pass adds that carry back in. The block suits area-constrained datapaths where a WIDTH-bit parallel adder is not wanted.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
start  input  1  request; accepted only when ready=1
a  input  WIDTH  first operand, one's-complement encoded; sampled on accept
b  input  WIDTH  second operand; sampled on accept
ready  output  1  high in IDLE only
busy  output  1  high in ADD or WRAP
valid  output  1  one-cycle pulse, sum/eac valid
sum  output  WIDTH  one's-complement result; holds until next accept
eac  output  1  end-around carry occurred in last operation; holds with sum

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst_n is asynchronous assert, active-low.
  - Reset values: ready=1, busy=0, valid=0, sum=0, eac=0, state=IDLE, carry=0, bit counter=0.
- States: IDLE, ADD, WRAP, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch a and b into shift registers, clear carry, clear counter, go to ADD.
  - start=0 keeps the block in IDLE.
- ADD (WIDTH cycles):
  - Each cycle: s = a_sr[0]^b_sr[0]^carry, carry <= majority(a_sr[0], b_sr[0], carry).
  - Shift both operand registers right.
  - Shift s into the sum register MSB, so after WIDTH cycles the sum register is LSB-aligned.
  - Counter increments. The last cycle is counter==WIDTH-1.
  - On the last cycle, compute the final carry-out (the majority term).
    - Carry-out 1: go to WRAP. Load a_sr <= new sum word, b_sr <= 0, carry <= 1, eac <= 1, counter <= 0.
    - Carry-out 0: go to DONE with eac <= 0.
- WRAP (WIDTH cycles):
  - Same serial step, adding the latched carry into the sum.
  - Cannot produce a further carry, because a+b-2^WIDTH+1 <= 2^WIDTH-1.
  - Any residual carry is discarded.
  - After counter==WIDTH-1, go to DONE.
- DONE (1 cycle):
  - valid=1; sum and eac are final.
  - ready=0 in this cycle.
  - Next state is IDLE.
- Latency, accept edge to valid cycle: WIDTH+1 cycles without wrap, 2*WIDTH+1 with wrap.
- Back-to-back throughput: a new accept is possible the cycle after valid.
- Handshake:
  - start while busy or in DONE is ignored, with no queuing.
  - a and b may change freely after accept.
- Negative zero: an all-ones result (e.g. x + ~x) is output as all-ones and not normalised to zero.
- The sum output register updates only at the end of ADD/WRAP. Internal shifting is not visible on sum until DONE; use a separate work register.
- Reset mid-operation returns to IDLE immediately. No valid pulse is emitted and sum/eac are cleared.
- The counter width is clog2(WIDTH)+1 so that WIDTH itself is representable.

Decomposition:
- Shared package/header: state encoding localparams (IDLE=2'd0, ADD=2'd1, WRAP=2'd2, DONE=2'd3).
- One natural sub-module: full_adder_bit, a combinational 1-bit sum/carry cell instantiated once and shared by ADD and WRAP.
- Everything else stays in one module.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start -> valid 9 cycles after accept, sum=0x08, eac=0.
- a=0xFE (-1), b=0x02 -> raw 0x100 -> valid at 17 cycles, sum=0x01, eac=1.
- a=0xFF, b=0xFF (-0 + -0) -> raw 0x1FE -> sum=0xFF, eac=1 (negative zero retained).
- a=0x05, b=0xFA -> sum=0xFF, eac=0, latency 9.
- Busy-ignore: start pulses with a=0x11, b=0x22 during an ADD of 0x05+0x03 -> single valid with sum=0x08; next accept only after valid.
- Reset: assert rst_n=0 mid-WRAP of 0xFE+0x02 -> ready=1, sum=0, eac=0, no valid; then 0x01+0x01 -> sum=0x02 at 9 cycles.
